// File: rtl/rgb_status_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : rgb_status_encoder
//  Purpose  : Folds robot mode, fault, goal-reached events and a base-link
//             watchdog into one registered colour code for the LED
//             controller (0 = green, 1 = red, 2 = blue). On goal reached in
//             autonomous mode it blinks green/blue for BLINK_COUNT phases of
//             BLINK_CYCLES cycles each, starting green.
//  Ports    : FPGA_CLK1_50 in  1  system clock
//             RESET        in  1  synchronous reset, active-high
//             HEARTBEAT    in  1  one-cycle pulse per valid base-link frame
//             MODE_AUTO    in  1  level, 1 = autonomous, 0 = teleoperation
//             GOAL_REACHED in  1  one-cycle pulse, navigation goal reached
//             FAULT        in  1  level, any subsystem fault
//             RPM_RGB      out 8  colour code (only 0, 1, 2 are driven)
//             LINK_OK      out 1  1 while the watchdog has not expired
//             STATE        out 3  FSM state, debug only
//                                 (0 LINKDOWN, 1 TELEOP, 2 AUTO, 3 GOAL, 4 FAULT)
//  Revision : 1.0  initial release
// ============================================================================
module rgb_status_encoder #(
  parameter int unsigned WDT_CYCLES   = 25_000_000,
  parameter int unsigned BLINK_CYCLES = 12_500_000,
  parameter int unsigned BLINK_COUNT  = 6
) (
  input  logic       FPGA_CLK1_50,
  input  logic       RESET,
  input  logic       HEARTBEAT,
  input  logic       MODE_AUTO,
  input  logic       GOAL_REACHED,
  input  logic       FAULT,
  output logic [7:0] RPM_RGB,
  output logic       LINK_OK,
  output logic [2:0] STATE
);

  localparam int unsigned C_WDT_W   = (WDT_CYCLES   > 1) ? $clog2(WDT_CYCLES)   : 1;
  localparam int unsigned C_PHASE_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam int unsigned C_IDX_W   = (BLINK_COUNT  > 1) ? $clog2(BLINK_COUNT)  : 1;

  localparam logic [C_WDT_W-1:0]   C_WDT_MAX   = C_WDT_W'(WDT_CYCLES - 1);
  localparam logic [C_PHASE_W-1:0] C_PHASE_MAX = C_PHASE_W'(BLINK_CYCLES - 1);
  localparam logic [C_IDX_W-1:0]   C_IDX_MAX   = C_IDX_W'(BLINK_COUNT - 1);

  localparam logic [7:0] C_GREEN = 8'd0;
  localparam logic [7:0] C_RED   = 8'd1;
  localparam logic [7:0] C_BLUE  = 8'd2;

  typedef enum logic [2:0] {
    ST_LINKDOWN = 3'd0,
    ST_TELEOP   = 3'd1,
    ST_AUTO     = 3'd2,
    ST_GOAL     = 3'd3,
    ST_FAULT    = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [C_WDT_W-1:0]   wdt_q, wdt_d;
  logic [C_PHASE_W-1:0] phase_q, phase_d;
  logic [C_IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]           rgb_q, rgb_d;
  logic                 timeout_q;
  logic                 link_ok_q;
  logic                 timeout;
  state_t               mode_st;

  // --------------------------------------------------------------------------
  // Watchdog and next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    // A heartbeat on the saturation cycle suppresses the timeout.
    timeout = (wdt_q == C_WDT_MAX) && !HEARTBEAT;

    if (HEARTBEAT) begin
      wdt_d = '0;
    end else if (wdt_q == C_WDT_MAX) begin
      wdt_d = wdt_q;
    end else begin
      wdt_d = wdt_q + 1'b1;
    end

    mode_st = MODE_AUTO ? ST_AUTO : ST_TELEOP;

    // Blink counters are only meaningful in GOAL; elsewhere they sit at zero.
    state_d = state_q;
    phase_d = '0;
    idx_d   = '0;

    if (FAULT) begin
      state_d = ST_FAULT;
    end else if (timeout) begin
      state_d = ST_LINKDOWN;
    end else begin
      case (state_q)
        ST_LINKDOWN, ST_FAULT, ST_TELEOP: begin
          // Goal events outside AUTO are dropped, never queued.
          state_d = mode_st;
        end
        ST_AUTO: begin
          if (GOAL_REACHED) begin
            state_d = ST_GOAL;
          end else begin
            state_d = mode_st;
          end
        end
        ST_GOAL: begin
          if (!MODE_AUTO) begin
            state_d = ST_TELEOP;
          end else if (GOAL_REACHED) begin
            // Restart the blink from the first (green) phase.
            state_d = ST_GOAL;
          end else if (phase_q == C_PHASE_MAX) begin
            if (idx_q == C_IDX_MAX) begin
              state_d = ST_AUTO;
            end else begin
              state_d = ST_GOAL;
              idx_d   = idx_q + 1'b1;
            end
          end else begin
            state_d = ST_GOAL;
            phase_d = phase_q + 1'b1;
            idx_d   = idx_q;
          end
        end
        default: begin
          state_d = ST_LINKDOWN;
        end
      endcase
    end

    // Colour is derived from the next state so it registers alongside it.
    case (state_d)
      ST_TELEOP: rgb_d = C_GREEN;
      ST_AUTO:   rgb_d = C_BLUE;
      ST_GOAL:   rgb_d = idx_d[0] ? C_BLUE : C_GREEN;
      default:   rgb_d = C_RED;
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge FPGA_CLK1_50) begin
    if (RESET) begin
      state_q   <= ST_LINKDOWN;
      wdt_q     <= C_WDT_MAX;
      phase_q   <= '0;
      idx_q     <= '0;
      rgb_q     <= C_RED;
      timeout_q <= 1'b1;
      link_ok_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wdt_q     <= wdt_d;
      phase_q   <= phase_d;
      idx_q     <= idx_d;
      rgb_q     <= rgb_d;
      // Two-stage path: a heartbeat sampled at edge N shows on LINK_OK
      // after edge N+1, one cycle behind the colour code.
      timeout_q <= timeout;
      link_ok_q <= !timeout_q;
    end
  end

  assign RPM_RGB = rgb_q;
  assign LINK_OK = link_ok_q;
  assign STATE   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_rgb_status_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_rgb_status_encoder
//  Purpose  : Self-checking bench for rgb_status_encoder with a behavioural
//             model (cycles-since-heartbeat and goal start time) plus
//             directed scenarios with literal expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rgb_status_encoder;

  localparam int WDT = 16;
  localparam int BC  = 4;
  localparam int BN  = 4;

  localparam int M_DOWN  = 0;
  localparam int M_TELE  = 1;
  localparam int M_AUTO  = 2;
  localparam int M_GOAL  = 3;
  localparam int M_FAULT = 4;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       hb   = 1'b0;
  logic       mode = 1'b0;
  logic       gr   = 1'b0;
  logic       flt  = 1'b0;
  logic [7:0] rgb;
  logic       link;
  logic [2:0] st;

  always #10 clk = ~clk;

  rgb_status_encoder #(
    .WDT_CYCLES  (WDT),
    .BLINK_CYCLES(BC),
    .BLINK_COUNT (BN)
  ) dut (
    .FPGA_CLK1_50(clk),
    .RESET       (rst),
    .HEARTBEAT   (hb),
    .MODE_AUTO   (mode),
    .GOAL_REACHED(gr),
    .FAULT       (flt),
    .RPM_RGB     (rgb),
    .LINK_OK     (link),
    .STATE       (st)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model: time since last heartbeat, mode, goal start time.
  // --------------------------------------------------------------------------
  int m_state = M_DOWN;
  int m_since = WDT - 1;
  int m_t0    = 0;
  int m_cyc   = 0;
  int m_rgb   = 1;
  bit m_prev_alive = 1'b0;
  bit m_link  = 1'b0;

  function automatic int colour(input int s, input int t0, input int now);
    case (s)
      M_TELE:  return 0;
      M_AUTO:  return 2;
      M_GOAL:  return (((now - t0) / BC) % 2) == 1 ? 2 : 0;
      default: return 1;
    endcase
  endfunction

  initial begin
    bit alive;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_state      = M_DOWN;
        m_since      = WDT - 1;
        m_prev_alive = 1'b0;
        m_link       = 1'b0;
      end else begin
        alive        = hb || (m_since < WDT - 1);
        m_link       = m_prev_alive;
        m_prev_alive = alive;
        if (hb) m_since = 0;
        else if (m_since < 1000) m_since = m_since + 1;
        if (flt) m_state = M_FAULT;
        else if (!alive) m_state = M_DOWN;
        else if (m_state == M_GOAL) begin
          if (!mode) m_state = M_TELE;
          else if (gr) m_t0 = m_cyc;
          else if (m_cyc - m_t0 >= BC * BN) m_state = M_AUTO;
        end else if (m_state == M_AUTO && gr) begin
          m_state = M_GOAL;
          m_t0    = m_cyc;
        end else begin
          m_state = mode ? M_AUTO : M_TELE;
        end
      end
      m_rgb = colour(m_state, m_t0, m_cyc);
      m_cyc++;
    end
  end

  // Compare process: every cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("model_rgb",   rgb,  m_rgb);
        chk("model_link",  link, m_link);
        chk("model_state", st,   m_state);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  int hb_ph = 0;

  task automatic tick(input bit h, input bit g);
    hb = h;
    gr = g;
    @(negedge clk);
    hb = 1'b0;
    gr = 1'b0;
  endtask

  // Heartbeat every 8 cycles keeps the link alive.
  task automatic beat(input bit g);
    tick(hb_ph == 0, g);
    hb_ph = (hb_ph + 1) % 8;
  endtask

  int seq[17] = '{0, 0, 0, 0, 2, 2, 2, 2, 0, 0, 0, 0, 2, 2, 2, 2, 2};

  initial begin
    int exp_c;
    rst = 1'b1;
    @(negedge clk);
    chk("reset_rgb",   rgb,  1);
    chk("reset_link",  link, 0);
    chk("reset_state", st,   0);
    rst    = 1'b0;
    chk_en = 1'b1;

    // 1: no heartbeat -> red, link down
    for (int i = 0; i < 40; i++) begin
      tick(1'b0, 1'b0);
      chk("t1_rgb",  rgb,  1);
      chk("t1_link", link, 0);
    end

    // 2: heartbeats, teleop -> green; then auto -> blue
    hb_ph = 0;
    beat(1'b0);
    chk("t2_green",    rgb,  0);
    chk("t2_link_lat", link, 0);
    beat(1'b0);
    chk("t2_link", link, 1);
    repeat (14) beat(1'b0);
    mode = 1'b1;
    beat(1'b0);
    chk("t2_blue", rgb, 2);

    // 3: heartbeat stops -> red exactly 16 cycles after last pulse
    tick(1'b1, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      tick(1'b0, 1'b0);
      if (k < 16) chk("t3_hold", rgb, 2);
      else        chk("t3_timeout", rgb, 1);
    end
    tick(1'b1, 1'b0);
    chk("t3_recover", rgb, 2);
    hb_ph = 1;

    // 4: goal blink, then restart at phase 2
    for (int i = 0; i < 17; i++) begin
      beat(i == 0);
      chk("t4_seq", rgb, seq[i]);
    end
    for (int i = 0; i < 28; i++) begin
      beat(i == 0 || i == 8);
      if (i < 8)        exp_c = seq[i];
      else if (i <= 24) exp_c = seq[i - 8];
      else              exp_c = 2;
      chk("t4_restart", rgb, exp_c);
    end

    // 5: fault during goal, then release with link alive and link down
    beat(1'b1);
    repeat (5) beat(1'b0);
    flt = 1'b1;
    beat(1'b0);
    chk("t5_fault_rgb",   rgb, 1);
    chk("t5_fault_state", st,  4);
    repeat (10) beat(1'b0);
    flt = 1'b0;
    tick(1'b1, 1'b0);
    hb_ph = 1;
    chk("t5_mode", rgb, 2);
    for (int i = 0; i < 6; i++) begin
      beat(1'b0);
      chk("t5_noblink", rgb, 2);
    end
    flt = 1'b1;
    repeat (20) tick(1'b0, 1'b0);
    flt = 1'b0;
    tick(1'b0, 1'b0);
    chk("t5_linkdown", rgb, 1);
    tick(1'b1, 1'b0);
    chk("t5_restore", rgb, 2);

    // 6: heartbeat on the saturation cycle keeps the link up
    tick(1'b1, 1'b0);
    repeat (15) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    chk("t6_sat_link", link, 1);
    chk("t6_sat_rgb",  rgb,  2);
    tick(1'b0, 1'b0);
    chk("t6_link_a", link, 1);
    tick(1'b0, 1'b0);
    chk("t6_link_b", link, 1);

    // Reset mid-blink
    hb_ph = 1;
    beat(1'b1);
    repeat (5) beat(1'b0);
    rst = 1'b1;
    beat(1'b0);
    chk("t6_rst_rgb",   rgb,  1);
    chk("t6_rst_state", st,   0);
    chk("t6_rst_link",  link, 0);
    rst = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(39) == 0) mode = ~mode;
      if (flt) begin
        if ($urandom_range(19) == 0) flt = 1'b0;
      end else begin
        if ($urandom_range(149) == 0) flt = 1'b1;
      end
      rst = ($urandom_range(399) == 0);
      tick($urandom_range(5) == 0, $urandom_range(9) == 0);
    end
    rst = 1'b0;
    tick(1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
